// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the CPU port, the DMA/debug port, the memory-side bus and the
//   stall counter of dmem_arbiter.  Signal suffixes are named from the
//   arbiter's point of view (_i = into the arbiter, _o = out of it).
//   Modports:
//     slave  : the arbiter itself
//     master : requesters plus memory model (a testbench or SoC glue)
//   Signal groups:
//     cpu_*   : CPU MEM-stage request/response, cpu_stall_o to hazard logic
//     dma_*   : DMA/debug request/response
//     mem_*   : single-ported data memory strobe/address/data
//     stall_cnt_o : saturating count of CPU stall cycles
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_done_o;
  logic              cpu_stall_o;

  logic              dma_req_i;
  logic              dma_we_i;
  logic [ADDR_W-1:0] dma_addr_i;
  logic [DATA_W-1:0] dma_wdata_i;
  logic [DATA_W-1:0] dma_rdata_o;
  logic              dma_done_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  logic [15:0]       stall_cnt_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_done_o, cpu_stall_o,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    output dma_rdata_o, dma_done_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output stall_cnt_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_done_o, cpu_stall_o,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    input  dma_rdata_o, dma_done_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  stall_cnt_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-ported data memory between the CPU MEM stage and a
//   DMA/debug port.  Each request goes IDLE -> ISSUE -> (WAIT) -> DATA and
//   the winner gets a one-cycle done pulse in the following IDLE cycle.
//   Ties are broken round-robin.  The CPU sees a stall while its request
//   is outstanding, and those stall cycles are counted (saturating).
//   Ports:
//     clk_i : clock, rising edge
//     rst_i : asynchronous, active-high reset
//     bus   : dmem_arbiter_if.slave (CPU port, DMA port, memory bus,
//             stall counter)
//   Parameters:
//     ADDR_W  : byte address width
//     DATA_W  : word width
//     MEM_LAT : cycles from the mem_en_o cycle to valid mem_rdata_i (1..7)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DATA  = 2'd3
  } state_t;

  // WAIT lasts MEM_LAT-1 cycles: load MEM_LAT-2 and leave when it hits 0.
  localparam logic [2:0] LP_WAIT_INIT = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;
  localparam logic [ADDR_W-1:0] LP_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_dma;
  logic              r_own_dma;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_wait_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_cpu_done;
  logic              r_dma_done;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic [15:0]       r_stall_cnt;

  logic              w_cpu_elig;
  logic              w_dma_elig;
  logic              w_grant;
  logic              w_grant_dma;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_stall;

  // Eligibility and round-robin arbitration; a port is not eligible in its
  // own done cycle so a held request is not granted twice.
  always_comb begin
    w_cpu_elig  = bus.cpu_req_i & ~r_cpu_done;
    w_dma_elig  = bus.dma_req_i & ~r_dma_done;
    w_grant     = 1'b0;
    w_grant_dma = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant = w_cpu_elig | w_dma_elig;
      if (w_cpu_elig && w_dma_elig) begin
        w_grant_dma = ~r_last_dma;
      end else begin
        w_grant_dma = w_dma_elig;
      end
    end else begin
      w_grant     = 1'b0;
      w_grant_dma = 1'b0;
    end
  end

  // Request fields of the winning port.
  always_comb begin
    w_sel_we    = bus.cpu_we_i;
    w_sel_addr  = bus.cpu_addr_i;
    w_sel_wdata = bus.cpu_wdata_i;
    if (w_grant_dma) begin
      w_sel_we    = bus.dma_we_i;
      w_sel_addr  = bus.dma_addr_i;
      w_sel_wdata = bus.dma_wdata_i;
    end else begin
      w_sel_we    = bus.cpu_we_i;
      w_sel_addr  = bus.cpu_addr_i;
      w_sel_wdata = bus.cpu_wdata_i;
    end
  end

  // Next-state logic of the transaction sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (MEM_LAT > 1) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DATA:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch owner and request fields on the grant edge; last_grant follows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_dma <= 1'b1;
      r_own_dma  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_grant) begin
      r_last_dma <= w_grant_dma;
      r_own_dma  <= w_grant_dma;
      r_we       <= w_sel_we;
      r_addr     <= w_sel_addr & LP_ALIGN_MASK;
      r_wdata    <= w_sel_wdata;
    end
  end

  // Memory-latency counter, loaded while the strobe is on the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt <= 3'd0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= LP_WAIT_INIT;
    end else if (r_state == S_WAIT && r_wait_cnt != 3'd0) begin
      r_wait_cnt <= r_wait_cnt - 3'd1;
    end
  end

  // Registered memory strobe: high exactly in the ISSUE cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      r_mem_en <= w_grant;
      r_mem_we <= w_grant & w_sel_we;
    end
  end

  // Done pulses land in the IDLE cycle after DATA.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cpu_done <= 1'b0;
      r_dma_done <= 1'b0;
    end else begin
      r_cpu_done <= (r_state == S_DATA) & ~r_own_dma;
      r_dma_done <= (r_state == S_DATA) &  r_own_dma;
    end
  end

  // Read data capture for the owner; writes leave rdata untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else if (r_state == S_DATA && !r_we) begin
      if (r_own_dma) begin
        r_dma_rdata <= bus.mem_rdata_i;
      end else begin
        r_cpu_rdata <= bus.mem_rdata_i;
      end
    end
  end

  assign w_stall = bus.cpu_req_i & ~r_cpu_done;

  // Saturating count of CPU stall cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.cpu_rdata_o = r_cpu_rdata;
  assign bus.cpu_done_o  = r_cpu_done;
  assign bus.cpu_stall_o = w_stall;
  assign bus.dma_rdata_o = r_dma_rdata;
  assign bus.dma_done_o  = r_dma_done;
  assign bus.mem_en_o    = r_mem_en;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Two arbiters (MEM_LAT=1 and MEM_LAT=3) with memory responders that only
//   return valid data MEM_LAT cycles after the strobe.  A transaction-level
//   model (round-robin winner, completion cycles, memory contents, stall
//   totals) predicts every observed value.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;

  int total = 0;
  int bad   = 0;

  dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) if1 ();
  dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) if3 ();

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(L1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .bus(if1.slave));
  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(L3)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .bus(if3.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'd5;
    else return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Memory responders: writes commit on the strobe edge, read data is only
  // valid exactly MEM_LAT cycles after the strobe cycle.
  logic [31:0] mem1 [8];
  logic [31:0] mem3 [8];
  logic [3:0]  age1, age3;
  logic [4:0]  paddr1, paddr3;

  always @(posedge clk) begin
    if (rst1) begin
      for (int i = 0; i < 8; i++) mem1[i] <= init_word(i);
      age1 <= 4'd0;
    end else if (if1.mem_en_o) begin
      if (if1.mem_we_o) mem1[if1.mem_addr_o[4:2]] <= if1.mem_wdata_o;
      paddr1 <= if1.mem_addr_o;
      age1   <= 4'd1;
    end else if (age1 != 4'd0 && age1 != 4'd15) begin
      age1 <= age1 + 4'd1;
    end
  end

  always @(posedge clk) begin
    if (rst3) begin
      for (int i = 0; i < 8; i++) mem3[i] <= init_word(i);
      age3 <= 4'd0;
    end else if (if3.mem_en_o) begin
      if (if3.mem_we_o) mem3[if3.mem_addr_o[4:2]] <= if3.mem_wdata_o;
      paddr3 <= if3.mem_addr_o;
      age3   <= 4'd1;
    end else if (age3 != 4'd0 && age3 != 4'd15) begin
      age3 <= age3 + 4'd1;
    end
  end

  assign if1.mem_rdata_i = (age1 == 4'(L1)) ? mem1[paddr1[4:2]] : 32'hBAD0_BAD0;
  assign if3.mem_rdata_i = (age3 == 4'(L3)) ? mem3[paddr3[4:2]] : 32'hBAD0_BAD0;

  // Transaction-level model of the MEM_LAT=1 instance.
  logic [31:0] ref_mem [8];
  bit          m_last_dma;
  logic [31:0] m_cpu_rd, m_dma_rd;
  int          m_stall;

  task automatic model_access(input bit is_dma, input bit we, input logic [4:0] a,
                              input logic [31:0] d);
    if (we) ref_mem[a[4:2]] = d;
    else if (is_dma) m_dma_rd = ref_mem[a[4:2]];
    else m_cpu_rd = ref_mem[a[4:2]];
  endtask

  task automatic do_reset1();
    @(negedge clk);
    rst1 = 1'b1;
    if1.cpu_req_i = 1'b0; if1.cpu_we_i = 1'b0; if1.cpu_addr_i = 5'd0; if1.cpu_wdata_i = 32'd0;
    if1.dma_req_i = 1'b0; if1.dma_we_i = 1'b0; if1.dma_addr_i = 5'd0; if1.dma_wdata_i = 32'd0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
    m_last_dma = 1'b1;
    m_cpu_rd = 32'd0;
    m_dma_rd = 32'd0;
    m_stall = 0;
  endtask

  // One request per enabled port, issued together in cycle 0 on the
  // MEM_LAT=1 instance; checks strobe, address, done, stall cycle by cycle.
  task automatic run_txn(input bit c_on, input bit c_we, input logic [4:0] c_a,
                         input logic [31:0] c_d, input bit d_on, input bit d_we,
                         input logic [4:0] d_a, input logic [31:0] d_d);
    int c_iss, c_done, d_iss, d_done, last;
    bit cpu_first, cr, exp_en, exp_we;
    logic [4:0] exp_addr;
    logic [31:0] exp_wd;
    c_iss = -1; c_done = -1; d_iss = -1; d_done = -1;
    cpu_first = (c_on && d_on) ? m_last_dma : c_on;
    if (c_on && d_on) begin
      if (cpu_first) begin
        c_iss = 1; c_done = 2 + L1; d_iss = 3 + L1; d_done = 4 + 2 * L1;
      end else begin
        d_iss = 1; d_done = 2 + L1; c_iss = 3 + L1; c_done = 4 + 2 * L1;
      end
      m_last_dma = cpu_first;
    end else if (c_on) begin
      c_iss = 1; c_done = 2 + L1; m_last_dma = 1'b0;
    end else begin
      d_iss = 1; d_done = 2 + L1; m_last_dma = 1'b1;
    end
    if (cpu_first) begin
      model_access(1'b0, c_we, c_a, c_d);
      if (d_on) model_access(1'b1, d_we, d_a, d_d);
    end else begin
      model_access(1'b1, d_we, d_a, d_d);
      if (c_on) model_access(1'b0, c_we, c_a, c_d);
    end
    if (c_on) m_stall = (m_stall + c_done > 65535) ? 65535 : m_stall + c_done;
    last = (c_done > d_done) ? c_done : d_done;

    if1.cpu_req_i = c_on; if1.cpu_we_i = c_we; if1.cpu_addr_i = c_a; if1.cpu_wdata_i = c_d;
    if1.dma_req_i = d_on; if1.dma_we_i = d_we; if1.dma_addr_i = d_a; if1.dma_wdata_i = d_d;
    cr = c_on;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (k == 2) begin
        // fields may change once latched
        if1.cpu_addr_i = ~c_a; if1.cpu_wdata_i = ~c_d;
        if1.dma_addr_i = ~d_a; if1.dma_wdata_i = ~d_d;
        if (k < c_iss) begin if1.cpu_addr_i = c_a; if1.cpu_wdata_i = c_d; end
        if (k < d_iss) begin if1.dma_addr_i = d_a; if1.dma_wdata_i = d_d; end
      end
      exp_en = (k == c_iss) || (k == d_iss);
      total++;
      if (if1.mem_en_o !== exp_en) begin
        bad++; $display("FAIL mem_en cyc=%0d got=%b exp=%b", k, if1.mem_en_o, exp_en);
      end
      if (exp_en) begin
        exp_addr = (k == c_iss) ? (c_a & 5'h1C) : (d_a & 5'h1C);
        exp_we   = (k == c_iss) ? c_we : d_we;
        exp_wd   = (k == c_iss) ? c_d : d_d;
        total++;
        if (if1.mem_addr_o !== exp_addr || if1.mem_we_o !== exp_we) begin
          bad++; $display("FAIL mem_addr_we cyc=%0d got=%h/%b exp=%h/%b", k,
                          if1.mem_addr_o, if1.mem_we_o, exp_addr, exp_we);
        end
        if (exp_we) begin
          total++;
          if (if1.mem_wdata_o !== exp_wd) begin
            bad++; $display("FAIL mem_wdata got=%h exp=%h", if1.mem_wdata_o, exp_wd);
          end
        end
      end
      total++;
      if (if1.cpu_done_o !== (k == c_done) || if1.dma_done_o !== (k == d_done)) begin
        bad++; $display("FAIL done cyc=%0d got=%b%b exp_cpu_cyc=%0d exp_dma_cyc=%0d", k,
                        if1.cpu_done_o, if1.dma_done_o, c_done, d_done);
      end
      total++;
      if (if1.cpu_stall_o !== (cr && k != c_done)) begin
        bad++; $display("FAIL cpu_stall cyc=%0d got=%b exp=%b", k, if1.cpu_stall_o,
                        (cr && k != c_done));
      end
      if (k == c_done) begin cr = 1'b0; if1.cpu_req_i = 1'b0; end
      if (k == d_done) if1.dma_req_i = 1'b0;
    end
    total++;
    if (if1.cpu_rdata_o !== m_cpu_rd || if1.dma_rdata_o !== m_dma_rd) begin
      bad++; $display("FAIL rdata got=%h/%h exp=%h/%h", if1.cpu_rdata_o, if1.dma_rdata_o,
                      m_cpu_rd, m_dma_rd);
    end
    total++;
    if (if1.stall_cnt_o !== 16'(m_stall)) begin
      bad++; $display("FAIL stall_cnt got=%0d exp=%0d", if1.stall_cnt_o, m_stall);
    end
  endtask

  task automatic test_reset();
    do_reset1();
    total++;
    if (if1.mem_en_o !== 1'b0 || if1.mem_we_o !== 1'b0 || if1.cpu_done_o !== 1'b0 ||
        if1.dma_done_o !== 1'b0 || if1.cpu_rdata_o !== 32'd0 || if1.dma_rdata_o !== 32'd0 ||
        if1.stall_cnt_o !== 16'd0 || if1.mem_addr_o !== 5'd0 || if1.mem_wdata_o !== 32'd0) begin
      bad++; $display("FAIL reset_state got en=%b we=%b dn=%b%b rd=%h/%h cnt=%0d a=%h wd=%h exp all 0",
                      if1.mem_en_o, if1.mem_we_o, if1.cpu_done_o, if1.dma_done_o, if1.cpu_rdata_o,
                      if1.dma_rdata_o, if1.stall_cnt_o, if1.mem_addr_o, if1.mem_wdata_o);
    end
  endtask

  task automatic test_cpu_read();
    run_txn(1'b1, 1'b0, 5'h04, 32'd0, 1'b0, 1'b0, 5'h00, 32'd0);
    total++;
    if (if1.cpu_rdata_o !== 32'd5 || if1.stall_cnt_o !== 16'd3) begin
      bad++; $display("FAIL cpu_read got=%h cnt=%0d exp=5 cnt=3", if1.cpu_rdata_o, if1.stall_cnt_o);
    end
  endtask

  task automatic test_dma_write_cpu_read();
    run_txn(1'b0, 1'b0, 5'h00, 32'd0, 1'b1, 1'b1, 5'h1C, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b0, 5'h1F, 32'd0, 1'b0, 1'b0, 5'h00, 32'd0);
    total++;
    if (if1.cpu_rdata_o !== 32'hDEAD_BEEF || if1.dma_rdata_o !== 32'd0) begin
      bad++; $display("FAIL dma_wr_cpu_rd got=%h/%h exp=deadbeef/0", if1.cpu_rdata_o, if1.dma_rdata_o);
    end
  endtask

  task automatic test_tie();
    do_reset1();
    run_txn(1'b1, 1'b0, 5'h08, 32'd0, 1'b1, 1'b0, 5'h0C, 32'd0);
    run_txn(1'b1, 1'b1, 5'h10, 32'h1234_5678, 1'b1, 1'b0, 5'h10, 32'd0);
    run_txn(1'b0, 1'b0, 5'h00, 32'd0, 1'b1, 1'b0, 5'h14, 32'd0);
    run_txn(1'b1, 1'b0, 5'h14, 32'd0, 1'b1, 1'b1, 5'h14, 32'hCAFE_F00D);
  endtask

  task automatic test_random();
    int mode;
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(1, 3));
      run_txn(mode[0], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              mode[1], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
  endtask

  task automatic test_lat3();
    @(negedge clk);
    rst3 = 1'b0;
    if3.cpu_req_i = 1'b1; if3.cpu_we_i = 1'b0; if3.cpu_addr_i = 5'h06; if3.cpu_wdata_i = 32'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (if3.mem_en_o !== (k == 1) || if3.cpu_done_o !== (k == 5) ||
          if3.cpu_stall_o !== (k < 5)) begin
        bad++; $display("FAIL lat3 cyc=%0d got en=%b done=%b stall=%b", k,
                        if3.mem_en_o, if3.cpu_done_o, if3.cpu_stall_o);
      end
      if (k == 5) if3.cpu_req_i = 1'b0;
    end
    total++;
    if (if3.cpu_rdata_o !== 32'd5 || if3.stall_cnt_o !== 16'd5) begin
      bad++; $display("FAIL lat3_result got=%h cnt=%0d exp=5 cnt=5", if3.cpu_rdata_o, if3.stall_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    if3.dma_req_i = 1'b1; if3.dma_we_i = 1'b0; if3.dma_addr_i = 5'h08; if3.dma_wdata_i = 32'd0;
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    if3.dma_req_i = 1'b0;
    #1;
    total++;
    if (if3.mem_en_o !== 1'b0 || if3.dma_done_o !== 1'b0 || if3.cpu_done_o !== 1'b0 ||
        if3.stall_cnt_o !== 16'd0) begin
      bad++; $display("FAIL reset_mid got en=%b dn=%b%b cnt=%0d exp 0", if3.mem_en_o,
                      if3.cpu_done_o, if3.dma_done_o, if3.stall_cnt_o);
    end
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (if3.dma_done_o !== 1'b0 || if3.mem_en_o !== 1'b0) begin
        bad++; $display("FAIL no_done_after_reset cyc=%0d got dn=%b en=%b exp 0", k,
                        if3.dma_done_o, if3.mem_en_o);
      end
    end
    if3.cpu_req_i = 1'b1; if3.cpu_we_i = 1'b0; if3.cpu_addr_i = 5'h10;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (if3.cpu_done_o !== (k == 2 + L3)) begin
        bad++; $display("FAIL post_reset_done cyc=%0d got=%b exp=%b", k, if3.cpu_done_o, (k == 2 + L3));
      end
      if (k == 2 + L3) if3.cpu_req_i = 1'b0;
    end
    total++;
    if (if3.cpu_rdata_o !== init_word(4) || if3.dma_rdata_o !== 32'd0) begin
      bad++; $display("FAIL post_reset_rdata got=%h/%h exp=%h/0", if3.cpu_rdata_o,
                      if3.dma_rdata_o, init_word(4));
    end
  endtask

  task automatic test_saturation();
    int n;
    bit held;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    if3.cpu_req_i = 1'b1; if3.cpu_we_i = 1'b0; if3.cpu_addr_i = 5'h00;
    if3.dma_req_i = 1'b1; if3.dma_we_i = 1'b0; if3.dma_addr_i = 5'h04;
    n = 0;
    while (if3.stall_cnt_o !== 16'hFFFF && n < 80000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (if3.stall_cnt_o !== 16'hFFFF) begin
      bad++; $display("FAIL saturate_reach got=%h exp=ffff after %0d cycles", if3.stall_cnt_o, n);
    end
    // CPU stalls at most 9 of every 10 cycles, so reaching 65535 takes > 65535
    total++;
    if (n < 65535) begin
      bad++; $display("FAIL saturate_rate got=%0d cycles exp>=65535", n);
    end
    held = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (if3.stall_cnt_o !== 16'hFFFF) held = 1'b0;
    end
    total++;
    if (!held) begin
      bad++; $display("FAIL saturate_hold got=%h exp=ffff", if3.stall_cnt_o);
    end
    if3.cpu_req_i = 1'b0;
    if3.dma_req_i = 1'b0;
  endtask

  initial begin
    if3.cpu_req_i = 1'b0; if3.cpu_we_i = 1'b0; if3.cpu_addr_i = 5'd0; if3.cpu_wdata_i = 32'd0;
    if3.dma_req_i = 1'b0; if3.dma_we_i = 1'b0; if3.dma_addr_i = 5'd0; if3.dma_wdata_i = 32'd0;
    test_reset();
    test_cpu_read();
    test_dma_write_cpu_read();
    test_tie();
    test_random();
    test_lat3();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
